// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants and types used by the fetch stage and its
// pipeline register.
package riscv_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } if_id_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch stage bus: instruction memory port, hazard/redirect controls and the
// IF/ID outputs seen by decode.
interface instruction_fetch_if;

  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectTarget;
  logic        IfIdValid;
  logic [31:0] IfIdPc;
  logic [31:0] IfIdInstr;
  logic [31:0] IfIdPcPlus4;
  logic        Halted;
  logic        Fault;
  logic [31:0] FetchCount;

  modport master (
    output Address,
    input  Instruction,
    input  Stall,
    input  Redirect,
    input  RedirectTarget,
    output IfIdValid,
    output IfIdPc,
    output IfIdInstr,
    output IfIdPcPlus4,
    output Halted,
    output Fault,
    output FetchCount
  );

  modport slave (
    input  Address,
    output Instruction,
    output Stall,
    output Redirect,
    output RedirectTarget,
    input  IfIdValid,
    input  IfIdPc,
    input  IfIdInstr,
    input  IfIdPcPlus4,
    input  Halted,
    input  Fault,
    input  FetchCount
  );

endinterface

// File: rtl/instruction_fetch_if_id_register.sv
// IF/ID pipeline register. hold wins over load, load wins over clear; clear
// drops only the valid bit so decode can still inspect the last word.
module if_id_register
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   hold,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q.valid   <= 1'b0;
      q.pc      <= 32'h0000_0000;
      q.instr   <= NOP_INSTR;
      q.pcplus4 <= 32'h0000_0004;
    end else if (!hold) begin
      if (load) begin
        q <= d;
      end else if (clear) begin
        q.valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, next-PC selection, range/alignment checks, the
// run/halt/fault state machine and the fetched-instruction counter.
//
// state  | meaning
// RUN    | normal fetch; redirect > stall > fetch
// HALTED | EBREAK was fetched; PC frozen until reset
// FAULT  | misaligned redirect or fetch past memory; frozen until reset
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input logic               clk,
  input logic               rst,
  instruction_fetch_if.master bus
);

  // 33 bits so a full 4 GiB memory limit cannot wrap to zero
  localparam logic [32:0] PC_LIMIT = 33'(4 * IMEM_WORDS);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  pc_plus4;
  logic         if_load, if_hold, if_clear;
  if_id_t       if_d, if_q;

  assign pc_plus4 = pc_q + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    if_load  = 1'b0;
    if_hold  = 1'b0;
    if_clear = 1'b0;
    if_d     = '{valid: 1'b1, pc: pc_q, instr: bus.Instruction, pcplus4: pc_plus4};

    unique case (state_q)
      RUN: begin
        if (bus.Redirect) begin
          if_clear = 1'b1;
          if (bus.RedirectTarget[1:0] == 2'b00) begin
            pc_d = bus.RedirectTarget;
          end else begin
            state_d = FAULT;
          end
        end else if (bus.Stall) begin
          if_hold = 1'b1;
        end else if ({1'b0, pc_q} >= PC_LIMIT) begin
          if_clear = 1'b1;
          state_d  = FAULT;
        end else begin
          if_load = 1'b1;
          count_d = count_q + 32'd1;
          // EBREAK is delivered to decode but the PC stays on it
          if (bus.Instruction == EBREAK_INSTR) begin
            state_d = HALTED;
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      default: begin
        if (bus.Stall) begin
          if_hold = 1'b1;
        end else begin
          if_clear = 1'b1;
        end
      end
    endcase
  end

  if_id_register u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (if_load),
    .hold  (if_hold),
    .clear (if_clear),
    .d     (if_d),
    .q     (if_q)
  );

  assign bus.Address     = pc_q;
  assign bus.IfIdValid   = if_q.valid;
  assign bus.IfIdPc      = if_q.pc;
  assign bus.IfIdInstr   = if_q.instr;
  assign bus.IfIdPcPlus4 = if_q.pcplus4;
  assign bus.Halted      = (state_q == HALTED);
  assign bus.Fault       = (state_q == FAULT);
  assign bus.FetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed steps push the expected
// post-edge outputs, a monitor pops and compares after each edge or reset.
module tb_instruction_fetch;
  import riscv_pkg::*;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
    logic        halted;
    logic        fault;
    logic [31:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [31:0] imem [0:63];
  exp_t exp_q[$];
  exp_t me;
  int total = 0;
  int bad = 0;

  instruction_fetch_if bus ();

  instruction_fetch #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_WORDS (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  always_comb begin
    if (bus.Address[31:8] == 24'd0) bus.Instruction = imem[bus.Address[7:2]];
    else bus.Instruction = 32'h0000_0000;
  end

  function automatic logic [31:0] addi(int i);
    return {12'(i), 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  function automatic exp_t mk(string tag, logic [31:0] addr, logic valid,
                              logic [31:0] pc, logic [31:0] instr, logic [31:0] p4,
                              logic halted, logic fault, logic [31:0] cnt);
    exp_t e;
    e.tag = tag; e.addr = addr; e.valid = valid; e.pc = pc; e.instr = instr;
    e.p4 = p4; e.halted = halted; e.fault = fault; e.cnt = cnt;
    return e;
  endfunction

  task automatic chk(string tag, string field, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s.%s: got %h required %h", tag, field, act, req);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    #1;
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk(me.tag, "Address",     bus.Address,             me.addr);
      chk(me.tag, "IfIdValid",   32'(bus.IfIdValid),      32'(me.valid));
      chk(me.tag, "IfIdPc",      bus.IfIdPc,              me.pc);
      chk(me.tag, "IfIdInstr",   bus.IfIdInstr,           me.instr);
      chk(me.tag, "IfIdPcPlus4", bus.IfIdPcPlus4,         me.p4);
      chk(me.tag, "Halted",      32'(bus.Halted),         32'(me.halted));
      chk(me.tag, "Fault",       32'(bus.Fault),          32'(me.fault));
      chk(me.tag, "FetchCount",  bus.FetchCount,          me.cnt);
    end
  end

  // called at a negedge; returns at the following negedge
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt, input exp_t e);
    bus.Stall = st;
    bus.Redirect = rd;
    bus.RedirectTarget = tgt;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.Stall = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectTarget = 32'd0;
    exp_q.push_back(mk("reset", 32'h0, 1'b0, 32'h0, NOP_INSTR, 32'h4, 1'b0, 1'b0, 32'd0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Stall = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectTarget = 32'd0;
    for (int i = 0; i < 64; i++) imem[i] = addi(i);
    @(negedge clk);

    do_reset();
    step(0, 0, 32'h0, mk("run1",   32'd4,  1, 32'd0, addi(0), 32'd4,  0, 0, 1));
    step(0, 0, 32'h0, mk("run2",   32'd8,  1, 32'd4, addi(1), 32'd8,  0, 0, 2));
    repeat (3)
      step(1, 0, 32'h0, mk("stall", 32'd8, 1, 32'd4, addi(1), 32'd8,  0, 0, 2));
    step(0, 0, 32'h0, mk("resume", 32'd12, 1, 32'd8, addi(2), 32'd12, 0, 0, 3));
    step(0, 0, 32'h0, mk("run4",   32'd16, 1, 32'd12, addi(3), 32'd16, 0, 0, 4));
    step(1, 1, 32'h20, mk("redir_stall", 32'h20, 0, 32'd12, addi(3), 32'd16, 0, 0, 4));
    step(0, 0, 32'h0, mk("redir_target", 32'h24, 1, 32'h20, addi(8), 32'h24, 0, 0, 5));
    step(0, 1, 32'h22, mk("misalign", 32'h24, 0, 32'h20, addi(8), 32'h24, 0, 1, 5));
    step(0, 1, 32'h40, mk("fault_redir", 32'h24, 0, 32'h20, addi(8), 32'h24, 0, 1, 5));
    step(0, 0, 32'h0, mk("fault_idle", 32'h24, 0, 32'h20, addi(8), 32'h24, 0, 1, 5));

    imem[5] = EBREAK_INSTR;
    do_reset();
    for (int k = 1; k <= 5; k++)
      step(0, 0, 32'h0, mk("eb_run", 32'(4*k), 1, 32'(4*(k-1)), addi(k-1), 32'(4*k), 0, 0, 32'(k)));
    step(0, 0, 32'h0, mk("ebreak",     32'd20, 1, 32'd20, EBREAK_INSTR, 32'd24, 1, 0, 6));
    step(1, 0, 32'h0, mk("halt_stall", 32'd20, 1, 32'd20, EBREAK_INSTR, 32'd24, 1, 0, 6));
    step(0, 1, 32'h40, mk("halt_clear", 32'd20, 0, 32'd20, EBREAK_INSTR, 32'd24, 1, 0, 6));
    step(0, 0, 32'h0, mk("halt_idle",  32'd20, 0, 32'd20, EBREAK_INSTR, 32'd24, 1, 0, 6));

    imem[5] = addi(5);
    do_reset();
    for (int k = 1; k <= 64; k++)
      step(0, 0, 32'h0, mk("span", 32'(4*k), 1, 32'(4*(k-1)), addi(k-1), 32'(4*k), 0, 0, 32'(k)));
    step(0, 0, 32'h0, mk("off_end", 32'd256, 0, 32'd252, addi(63), 32'd256, 0, 1, 64));

    do_reset();
    for (int k = 1; k <= 10; k++)
      step(0, 0, 32'h0, mk("pass2", 32'(4*k), 1, 32'(4*(k-1)), addi(k-1), 32'(4*k), 0, 0, 32'(k)));
    // reset lands mid-cycle while stalled
    bus.Stall = 1'b1;
    #2;
    exp_q.push_back(mk("mid_reset", 32'h0, 1'b0, 32'h0, NOP_INSTR, 32'h4, 1'b0, 1'b0, 32'd0));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.Stall = 1'b0;
    step(0, 0, 32'h0, mk("post_reset", 32'd4, 1, 32'd0, addi(0), 32'd4, 0, 0, 1));

    @(negedge clk);
    chk("end", "pending", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the RISC-V core: owns the program counter, drives the byte address to the instruction memory, samples the combinationally returned instruction word into the IF/ID pipeline register, and handles stalls, control-flow redirects, EBREAK halt and fetch faults. It sits directly upstream of the instruction memory and directly upstream of decode.

## Interface

**Parameters**
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- IMEM_WORDS, 64: number of 32-bit words in the instruction memory; sets the legal fetch range.

**Ports**
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Address  out  32  byte address to the instruction memory; equals the PC, combinational from the PC register.
- Instruction  in  32  word returned combinationally by the instruction memory for Address.
- Stall  in  1  hazard-unit hold; freezes the PC and IF/ID.
- Redirect  in  1  taken branch or jump from execute.
- RedirectTarget  in  32  new PC when Redirect is high.
- IfIdValid  out  1  IF/ID holds a real instruction.
- IfIdPc  out  32  PC of the IF/ID instruction.
- IfIdInstr  out  32  IF/ID instruction word.
- IfIdPcPlus4  out  32  IfIdPc + 4.
- Halted  out  1  high in state HALTED.
- Fault  out  1  high in state FAULT.
- FetchCount  out  32  number of instructions latched valid into IF/ID.

## Operation

- Reset values, asynchronous: PC = RESET_PC, state = RUN, IfIdValid = 0, IfIdInstr = NOP (32'h0000_0013), IfIdPc = 0, IfIdPcPlus4 = 4, FetchCount = 0, Halted = 0, Fault = 0.
- States:
  - RUN: normal fetch.
  - HALTED: terminal; left only by reset.
  - FAULT: terminal; left only by reset.
- Per-edge priority in RUN is Redirect, then Stall, then normal fetch.
  - **Redirect with RedirectTarget[1:0] == 0:** PC <= RedirectTarget; IfIdValid <= 0 (squash the wrong-path fetch). This applies even while Stall is high.
  - **Redirect with RedirectTarget[1:0] != 0:** next state FAULT; PC unchanged; IfIdValid <= 0.
  - **Stall (no Redirect):** PC, IF/ID and FetchCount all hold.
  - **Normal fetch, PC >= 4*IMEM_WORDS:** next state FAULT; IfIdValid <= 0; the instruction is not latched.
  - **Normal fetch, in range:** IF/ID <= {1, PC, Instruction, PC+4}; PC <= PC+4; FetchCount += 1, wrapping modulo 2^32.
  - **Normal fetch of EBREAK (32'h0010_0073):** latched valid as above and counted, so decode sees it. PC is not advanced. Next state HALTED.
- HALTED and FAULT:
  - PC frozen; Redirect is ignored.
  - If Stall is high, IF/ID holds. Otherwise IfIdValid <= 0 (IfIdPc, IfIdInstr and IfIdPcPlus4 hold their values).
- PC arithmetic is 32-bit unsigned; 32'hFFFF_FFFC + 4 wraps to 0. With default parameters the range check faults first.

## Timing

- Address is valid combinationally in the same cycle as the PC register. Instruction must settle in the same cycle.
- Fetch-to-IF/ID latency: 1 cycle. An instruction at PC in cycle N appears on the IfId outputs in cycle N+1.
- Redirect penalty: one bubble. Redirect in cycle N gives IfIdValid = 0 in N+1; the target instruction is valid in N+2.
- Halted and Fault rise one edge after the triggering cycle.
- rst asserted mid-operation immediately forces all reset values, regardless of state or Stall.

## Structure

- Shared package riscv_pkg:
  - NOP_INSTR = 32'h0000_0013
  - EBREAK_INSTR = 32'h0010_0073
  - enum fetch_state_t {RUN, HALTED, FAULT}
- Sub-module if_id_register: holds valid, pc, instr and pcplus4, with load, hold and clear-valid controls and asynchronous reset. It is reused when the pipeline registers are factored out.
- The top level holds the PC register, next-PC mux, range and alignment checks, the state machine and FetchCount.

## Test plan

- **Reset then free run** over memory with ADDI at words 0..3. Required: Address = 0, 4, 8, 12 on consecutive cycles; IfIdPc lags by one cycle; FetchCount = 4 after 4 edges.
- **Stall** high 3 cycles at PC = 8. Required: Address stays 8; IF/ID and FetchCount unchanged; fetch resumes at 8 when Stall drops.
- **Redirect** to 32'h20 while Stall is also high. Required: next Address = 32'h20 and IfIdValid = 0; the word at 32'h20 is valid in IF/ID one cycle later.
- **Misaligned redirect** to 32'h22. Required: Fault = 1 next edge; PC frozen; IfIdValid = 0; later Redirects ignored.
- **EBREAK** at word 5. Required: IfIdInstr = 32'h0010_0073 valid with IfIdPc = 20; Halted = 1; Address stays 20; next edge IfIdValid = 0.
- **Run off the end** (IMEM_WORDS = 64, no EBREAK), with rst asserted mid-run in a second pass:
  - Required at PC = 256: Fault = 1 and FetchCount = 64.
  - Required on rst: all outputs immediately return to their reset values.
